alu_nbit: RTL

ALU_NBIT -- requirements
Module: alu_nbit

---
 rtl/alu_nbit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_nbit.sv
// N-bit ALU with a valid/ready handshake and a registered result and flags.
// A multiply takes WIDTH shift-add cycles; every other op completes in one cycle.
module alu_nbit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      HOLD
   } state_t;

   state_t               state_reg;
   logic                 in_ready_reg;
   logic                 out_valid_reg;
   logic [WIDTH-1:0]     result_reg;
   logic                 carry_out_reg;
   logic                 overflow_reg;
   logic                 zero_reg;
   logic                 negative_reg;

   logic [2*WIDTH-1:0]   mul_prod_reg;
   logic [2*WIDTH-1:0]   mul_mcand_reg;
   logic [WIDTH-1:0]     mul_mplier_reg;
   logic [CW-1:0]        mul_cnt_reg;
   logic [2*WIDTH-1:0]   mul_prod_next;

   logic [WIDTH-1:0]     and_bits;
   logic [WIDTH-1:0]     or_bits;
   logic [WIDTH-1:0]     xor_bits;

   logic [WIDTH-1:0]     b_eff;
   logic                 c_eff;
   logic [WIDTH:0]       sum_full;
   logic                 add_ovf;
   logic                 slt_bit;
   logic [WIDTH-1:0]     alu_result_next;
   logic                 alu_carry_next;
   logic                 alu_ovf_next;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
         assign and_bits[gi] = A[gi] & B[gi];
         assign or_bits[gi]  = A[gi] | B[gi];
         assign xor_bits[gi] = A[gi] ^ B[gi];
      end
   endgenerate

   // SUB reuses the adder as A + ~B + 1; carry_in only matters for ADD.
   always_comb begin
      b_eff           = (op == OP_SUB) ? ~B : B;
      c_eff           = (op == OP_SUB) ? 1'b1 : ((op == OP_ADD) ? carry_in : 1'b0);
      sum_full        = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};
      add_ovf         = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != A[WIDTH-1]);
      slt_bit         = $signed(A) < $signed(B);
      alu_result_next = '0;
      alu_carry_next  = 1'b0;
      alu_ovf_next    = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            alu_result_next = sum_full[WIDTH-1:0];
            alu_carry_next  = sum_full[WIDTH];
            alu_ovf_next    = add_ovf;
         end
         OP_AND:  alu_result_next = and_bits;
         OP_OR:   alu_result_next = or_bits;
         OP_XOR:  alu_result_next = xor_bits;
         OP_SLT:  alu_result_next = {{(WIDTH-1){1'b0}}, slt_bit};
         default: alu_result_next = '0;
      endcase
   end

   assign mul_prod_next = mul_prod_reg + (mul_mplier_reg[0] ? mul_mcand_reg : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         in_ready_reg   <= 1'b1;
         out_valid_reg  <= 1'b0;
         result_reg     <= '0;
         carry_out_reg  <= 1'b0;
         overflow_reg   <= 1'b0;
         zero_reg       <= 1'b0;
         negative_reg   <= 1'b0;
         mul_prod_reg   <= '0;
         mul_mcand_reg  <= '0;
         mul_mplier_reg <= '0;
         mul_cnt_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  in_ready_reg <= 1'b0;
                  if (op == OP_MUL) begin
                     mul_prod_reg   <= '0;
                     mul_mcand_reg  <= {{WIDTH{1'b0}}, A};
                     mul_mplier_reg <= B;
                     mul_cnt_reg    <= '0;
                     state_reg      <= MUL;
                  end else begin
                     result_reg    <= alu_result_next;
                     carry_out_reg <= alu_carry_next;
                     overflow_reg  <= alu_ovf_next;
                     zero_reg      <= (alu_result_next == '0);
                     negative_reg  <= alu_result_next[WIDTH-1];
                     out_valid_reg <= 1'b1;
                     state_reg     <= HOLD;
                  end
               end
            end
            MUL: begin
               mul_prod_reg   <= mul_prod_next;
               mul_mcand_reg  <= mul_mcand_reg << 1;
               mul_mplier_reg <= mul_mplier_reg >> 1;
               mul_cnt_reg    <= mul_cnt_reg + 1'b1;
               if (mul_cnt_reg == LAST_STEP) begin
                  result_reg    <= mul_prod_next[WIDTH-1:0];
                  carry_out_reg <= 1'b0;
                  overflow_reg  <= |mul_prod_next[2*WIDTH-1:WIDTH];
                  zero_reg      <= (mul_prod_next[WIDTH-1:0] == '0);
                  negative_reg  <= mul_prod_next[WIDTH-1];
                  out_valid_reg <= 1'b1;
                  state_reg     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign carry_out = carry_out_reg;
   assign overflow  = overflow_reg;
   assign zero      = zero_reg;
   assign negative  = negative_reg;

endmodule
